audio_peak_hex: RTL and testbench

//  Peak-level meter between the audio codec read path and the hexDecoder stage.

---
 rtl/audio_peak_hex_if.sv | 25 ++
 rtl/audio_peak_hex.sv | 123 ++++++++++++
 tb/tb_audio_peak_hex.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_peak_hex_if.sv
`default_nettype none
// ============================================================================
//  audio_peak_hex_if : sample valid/ready handshake, codec -> peak meter
//  Revision 1.0
// ============================================================================
interface audio_peak_hex_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/audio_peak_hex.sv
`default_nettype none
// ============================================================================
//  audio_peak_hex : windowed peak |sample| meter feeding four hexDecoder nibbles
//  Revision 1.0
// ============================================================================
module audio_peak_hex #(
    parameter int              DATA_W      = 24,
    parameter int              WINDOW      = 48000,
    parameter logic [DATA_W-2:0] CLIP_THRESH = 23'h7F0000
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    audio_peak_hex_if.slave    s_if,
    input  wire logic          freeze,
    output logic [3:0]         hex3,
    output logic [3:0]         hex2,
    output logic [3:0]         hex1,
    output logic [3:0]         hex0,
    output logic               clip,
    output logic               peak_update
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_LATCH = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic [DATA_W-2:0]   run_max_q,  run_max_d;
    logic                run_clip_q, run_clip_d;
    logic [15:0]         disp_q,     disp_d;
    logic                clip_q,     clip_d;
    logic                pu_q,       pu_d;

    logic                ready_w;
    logic                accept_w;
    logic                is_min_w;
    logic [DATA_W-2:0]   neg_w;
    logic [DATA_W-2:0]   mag_w;

    // Most negative input has no positive counterpart; it saturates to full scale.
    assign is_min_w = s_if.sample_in[DATA_W-1] && ~|s_if.sample_in[DATA_W-2:0];
    assign neg_w    = ~s_if.sample_in[DATA_W-2:0] + 1'b1;
    assign mag_w    = !s_if.sample_in[DATA_W-1] ? s_if.sample_in[DATA_W-2:0] :
                      is_min_w                  ? {(DATA_W-1){1'b1}}         :
                                                  neg_w;

    assign ready_w           = (state_q == ST_ACCUM) && resetn;
    assign accept_w          = s_if.sample_valid && ready_w;
    assign s_if.sample_ready = ready_w;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        run_max_d  = run_max_q;
        run_clip_d = run_clip_q;
        disp_d     = disp_q;
        clip_d     = clip_q;
        pu_d       = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accept_w) begin
                    if (mag_w > run_max_q) begin
                        run_max_d = mag_w;
                    end
                    if (mag_w >= CLIP_THRESH) begin
                        run_clip_d = 1'b1;
                    end
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        state_d = ST_LATCH;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (!freeze) begin
                    disp_d = run_max_q[DATA_W-2 -: 16];
                    clip_d = run_clip_q;
                    pu_d   = 1'b1;
                end
                run_max_d  = '0;
                run_clip_d = 1'b0;
                state_d    = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            run_max_q  <= '0;
            run_clip_q <= 1'b0;
            disp_q     <= '0;
            clip_q     <= 1'b0;
            pu_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            run_max_q  <= run_max_d;
            run_clip_q <= run_clip_d;
            disp_q     <= disp_d;
            clip_q     <= clip_d;
            pu_q       <= pu_d;
        end
    end

    assign hex3        = disp_q[15:12];
    assign hex2        = disp_q[11:8];
    assign hex1        = disp_q[7:4];
    assign hex0        = disp_q[3:0];
    assign clip        = clip_q;
    assign peak_update = pu_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_peak_hex.sv
`default_nettype none
// ============================================================================
//  tb_audio_peak_hex : scoreboard bench for audio_peak_hex (WINDOW = 4)
//  Revision 1.0
// ============================================================================
module tb_audio_peak_hex;

    typedef logic [23:0] win_t [4];

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] hex3, hex2, hex1, hex0;
    logic       clip;
    logic       peak_update;

    audio_peak_hex_if #(.DATA_W(24)) bus ();

    audio_peak_hex #(
        .DATA_W      (24),
        .WINDOW      (4),
        .CLIP_THRESH (23'h7F0000)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .s_if        (bus),
        .freeze      (freeze),
        .hex3        (hex3),
        .hex2        (hex2),
        .hex1        (hex1),
        .hex0        (hex0),
        .clip        (clip),
        .peak_update (peak_update)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q [$];
    logic        pu_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every peak_update pops one expected {clip, display} entry.
    always @(negedge clock) begin
        if (resetn && peak_update) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_update: got hex %h%h%h%h clip %0b, expected no update",
                         hex3, hex2, hex1, hex0, clip);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sb_hex", {16'h0, hex3, hex2, hex1, hex0}, {16'h0, e[15:0]});
                check("sb_clip", {31'h0, clip}, {31'h0, e[16]});
            end
            if (pu_prev) begin
                n_cmp++;
                n_err++;
                $display("FAIL pulse_width: got peak_update high 2 cycles, expected 1");
            end
        end
        pu_prev <= peak_update;
    end

    task automatic idle(input int cycles);
        bus.sample_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offers one sample and returns 1 time unit after the edge that accepts it.
    task automatic send(input logic [23:0] s, input int gap, input int exp_stall);
        int   stall;
        logic r;
        stall = 0;
        if (gap > 0) idle(gap);
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
        forever begin
            @(negedge clock);
            r = bus.sample_ready;
            @(posedge clock);
            #1;
            if (r) break;
            stall++;
            if (stall > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got no accept in 20 cycles, expected accept");
                break;
            end
        end
        check("stall_cycles", stall, exp_stall);
    endtask

    task automatic send_win(input win_t s, input int gap, input int first_stall,
                            input logic push, input logic [16:0] exp);
        if (push) exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            send(s[i], gap, (i == 0) ? first_stall : 0);
        end
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;

        // Reset state
        #2;
        check("rst_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h0);
        check("rst_clip_pu_ready", {29'h0, clip, peak_update, bus.sample_ready}, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Basic window with latency checks
        send_win('{24'h000100, 24'hFFF000, 24'h123456, 24'h000001}, 0, 0, 1'b1, {1'b0, 16'h2468});
        bus.sample_valid = 1'b0;
        check("latch_pu_low", {31'h0, peak_update}, 32'h0);
        check("latch_ready_low", {31'h0, bus.sample_ready}, 32'h0);
        @(posedge clock);
        #1;
        check("upd_pu_high", {31'h0, peak_update}, 32'h1);
        check("upd_ready_high", {31'h0, bus.sample_ready}, 32'h1);
        check("upd_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h2468);
        @(posedge clock);
        #1;
        check("pu_cleared", {31'h0, peak_update}, 32'h0);
        idle(3);

        // Same samples, one valid every 5 cycles
        send_win('{24'h000100, 24'hFFF000, 24'h123456, 24'h000001}, 4, 0, 1'b1, {1'b0, 16'h2468});
        idle(3);

        // Back-to-back windows: saturation/clip, quiet window, negative peak
        send_win('{24'h001000, 24'h400000, 24'hC00000, 24'h800000}, 0, 0, 1'b1, {1'b1, 16'hFFFF});
        send_win('{24'h000010, 24'h000010, 24'h000010, 24'h000010}, 0, 1, 1'b1, {1'b0, 16'h0000});
        send_win('{24'hFFFFFF, 24'hF00000, 24'h000200, 24'h0FFFFF}, 0, 1, 1'b1, {1'b0, 16'h2000});
        idle(3);

        // Frozen display, then release
        freeze = 1'b1;
        send_win('{24'h000300, 24'h7F0000, 24'h810000, 24'h001000}, 0, 0, 1'b0, 17'h0);
        bus.sample_valid = 1'b0;
        @(posedge clock);
        #1;
        freeze = 1'b0;
        idle(2);
        check("frozen_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h2000);
        check("frozen_clip", {31'h0, clip}, 32'h0);
        send_win('{24'h000001, 24'hF54322, 24'h050000, 24'h000000}, 0, 0, 1'b1, {1'b0, 16'h1579});
        idle(3);

        // Reset mid-window discards the partial window
        send(24'h7FFFFF, 0, 0);
        send(24'h7FFFFF, 0, 0);
        bus.sample_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        check("midrst_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h0);
        check("midrst_clip_pu_ready", {29'h0, clip, peak_update, bus.sample_ready}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        send_win('{24'h000080, 24'h000100, 24'h000180, 24'h000000}, 0, 0, 1'b1, {1'b0, 16'h0003});
        idle(5);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
